// File: rtl/graphics_pixel_writer.sv
// graphics_pixel_writer: Avalon-ST pixel sink issuing one byte-enabled Avalon-MM frame-buffer write per pixel.
// Define GRAPHICS_PIXEL_CLIP_EN to discard out-of-bounds pixels instead of writing them.
package graphics_pkg;
   localparam int COORD_DATA_WIDTH = 16;
   typedef struct packed {
      logic signed [COORD_DATA_WIDTH-1:0] x;
      logic signed [COORD_DATA_WIDTH-1:0] y;
      logic [7:0]                         color;
      logic [7:0]                         padding;
   } pixel_t;
   localparam int ST_DATA_WIDTH = $bits(pixel_t);
endpackage

module graphics_pixel_writer
   import graphics_pkg::*;
#(
   parameter int          H_RES      = 640,
   parameter int          V_RES      = 480,
   parameter logic [31:0] FB_BASE    = 32'h0,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     st_valid,
   input  logic [ST_DATA_WIDTH-1:0] st_data,
   output logic                     st_ready,
   output logic                     mm_write,
   output logic [31:0]              mm_address,
   output logic [31:0]              mm_writedata,
   output logic [3:0]               mm_byteenable,
   input  logic                     mm_waitrequest,
   output logic                     idle
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = COORD_DATA_WIDTH;

   pixel_t        px;
   logic          accept, push, pop, s1_keep, unused_pad;
   logic          s1_valid_q, s2_valid_q;
   logic [CW-1:0] s1_x_q, s1_y_q;
   logic [7:0]    s1_color_q, s2_color_q;
   logic [31:0]   s2_addr_q;
   logic [3:0]    s2_be_q;
   logic [19:0]   linear;
   logic [31:0]   fifo_addr [FIFO_DEPTH];
   logic [3:0]    fifo_be [FIFO_DEPTH];
   logic [7:0]    fifo_color [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q, count_d;
   logic [AW+1:0] credit;

   assign px         = pixel_t'(st_data);
   assign unused_pad = ^px.padding;
   assign accept     = st_valid && st_ready;
   assign push       = s2_valid_q;
   assign pop        = mm_write && !mm_waitrequest;
   assign linear     = 20'({{(32-CW){1'b0}}, s1_y_q} * 32'(H_RES) + {{(32-CW){1'b0}}, s1_x_q});
   assign count_d    = count_q + (AW+1)'(push) - (AW+1)'(pop);

`ifdef GRAPHICS_PIXEL_CLIP_EN
   logic s1_oob_q, oob;
   assign oob = px.x[CW-1] || px.y[CW-1] || px.x >= CW'(H_RES) || px.y >= CW'(V_RES);
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) s1_oob_q <= 1'b0;
      else if (accept) s1_oob_q <= oob;
   assign s1_keep = !s1_oob_q;
`else
   assign s1_keep = 1'b1;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         s1_x_q     <= '0;
         s1_y_q     <= '0;
         s1_color_q <= '0;
         s2_addr_q  <= '0;
         s2_be_q    <= '0;
         s2_color_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         s1_valid_q <= accept;
         if (accept) begin
            s1_x_q     <= px.x;
            s1_y_q     <= px.y;
            s1_color_q <= px.color;
         end
         s2_valid_q <= s1_valid_q && s1_keep;
         if (s1_valid_q) begin
            s2_addr_q  <= FB_BASE + {12'd0, linear[19:2], 2'b00};
            s2_be_q    <= 4'b0001 << linear[1:0];
            s2_color_q <= s1_color_q;
         end
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk)
      if (push) begin
         fifo_addr[wr_ptr_q]  <= s2_addr_q;
         fifo_be[wr_ptr_q]    <= s2_be_q;
         fifo_color[wr_ptr_q] <= s2_color_q;
      end

   // Head entry is gated so the MM bus reads zero whenever nothing is queued.
   assign mm_write      = count_q != '0;
   assign mm_address    = mm_write ? fifo_addr[rd_ptr_q] : '0;
   assign mm_writedata  = mm_write ? {4{fifo_color[rd_ptr_q]}} : '0;
   assign mm_byteenable = mm_write ? fifo_be[rd_ptr_q] : '0;
   assign credit        = (AW+2)'(count_q) + (AW+2)'(s1_valid_q) + (AW+2)'(s2_valid_q);
   assign st_ready      = credit < (AW+2)'(FIFO_DEPTH);
   assign idle          = !s1_valid_q && !s2_valid_q && !mm_write;
endmodule
